// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared constants and types for the nibble-serial adder.
//   state_t      : controller FSM states (IDLE, RUN, DONE)
//   SLICE_W      : width of one adder slice (bits)
//   NIB_DEFAULT  : default number of slices per operand
package serial_add_pkg;

  localparam int SLICE_W     = 4;
  localparam int NIB_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle of the serial adder.
//   start, X, Y, Sub, Cin : request side, driven by the master
//   busy, done, Sum, Cout, Ovf : status/result side, driven by the slave
// W must equal SLICE_W * NIB of the attached serial_add_ctrl.
import serial_add_pkg::*;

interface serial_add_ctrl_if #(
  parameter int W = SLICE_W * NIB_DEFAULT
);
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Sub;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  modport master (
    output start, X, Y, Sub, Cin,
    input  busy, done, Sum, Cout, Ovf
  );

  modport slave (
    input  start, X, Y, Sub, Cin,
    output busy, done, Sum, Cout, Ovf
  );
endinterface

// File: rtl/serial_add_ctrl_add4.sv
// add4: purely combinational 4-bit ripple slice.
//   A, B : slice operands
//   Ci   : carry in
//   S    : slice sum
//   Co   : carry out of bit 3
//   Cmsb : carry into bit 3 (the overflow term when this is the top slice)
import serial_add_pkg::*;

module add4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co,
  output logic       Cmsb
);
  logic [3:0] low;  // bits 2:0 plus their carry out
  logic [1:0] high; // bit 3 plus the slice carry out

  always_comb begin
    low  = {1'b0, A[2:0]} + {1'b0, B[2:0]} + {3'b000, Ci};
    high = {1'b0, A[3]} + {1'b0, B[3]} + {1'b0, low[3]};
    S    = {high[0], low[2:0]};
    Co   = high[1];
    Cmsb = low[3];
  end
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds or subtracts two W-bit operands one 4-bit slice per
// cycle, LSB slice first, through a single add4 instance.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : serial_add_ctrl_if slave (start/X/Y/Sub/Cin in,
//          busy/done/Sum/Cout/Ovf out)
// Timing: accept in IDLE, NIB RUN cycles, one DONE cycle, then IDLE.
import serial_add_pkg::*;

module serial_add_ctrl #(
  parameter int NIB = NIB_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state_reg, state_next;

  logic [IW-1:0]                 idx_reg;
  logic [NIB-1:0][SLICE_W-1:0]   x_reg;
  logic [NIB-1:0][SLICE_W-1:0]   y_reg;   // already inverted for subtract
  logic                          carry_reg;
  logic [NIB-1:0][SLICE_W-1:0]   sum_reg;
  logic                          cout_reg;
  logic                          ovf_reg;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               slice_cmsb;
  logic               last_nib;

  assign last_nib = (idx_reg == IW'(NIB - 1));

  add4 u_add4 (
    .A    (x_reg[idx_reg]),
    .B    (y_reg[idx_reg]),
    .Ci   (carry_reg),
    .S    (slice_s),
    .Co   (slice_co),
    .Cmsb (slice_cmsb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_nib)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy = (state_reg != IDLE);
    bus.done = (state_reg == DONE);
  end

  assign bus.Sum  = sum_reg;
  assign bus.Cout = cout_reg;
  assign bus.Ovf  = ovf_reg;

  // Datapath: operand capture, slice commit, final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            idx_reg   <= '0;
            x_reg     <= bus.X;
            // Subtract is X + ~Y + 1: invert Y here and preload carry with 1
            y_reg     <= bus.Sub ? ~bus.Y : bus.Y;
            carry_reg <= bus.Sub ? 1'b1 : bus.Cin;
          end
        end
        RUN: begin
          sum_reg[idx_reg] <= slice_s;
          carry_reg        <= slice_co;
          if (last_nib) begin
            idx_reg  <= '0;
            cout_reg <= slice_co;
            ovf_reg  <= slice_co ^ slice_cmsb;
          end else begin
            idx_reg  <= idx_reg + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  serial_add_ctrl_if #(.W(W)) bus ();

  serial_add_ctrl #(.NIB(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic and sign rules
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic sub, input logic cin,
                                output logic [W-1:0] s, output logic co,
                                output logic ov);
    logic [W:0] full;
    if (sub) full = {1'b0, x} + (17'h10000 - {1'b0, y});
    else     full = {1'b0, x} + {1'b0, y} + {16'h0, cin};
    s  = full[W-1:0];
    co = full[W];
    if (sub) ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    else     ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // One operation; operands scrambled after acceptance.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sub, input logic cin,
                        output logic [W-1:0] s, output logic co,
                        output logic ov, output int lat);
    bit got;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.X = x; bus.Y = y; bus.Sub = sub; bus.Cin = cin;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      #1;
      bus.start = 1'b0;
      bus.X = W'($urandom); bus.Y = W'($urandom);
      bus.Sub = 1'($urandom); bus.Cin = 1'($urandom);
      @(negedge clk);
      if (bus.done) got = 1;
    end
    s = bus.Sum; co = bus.Cout; ov = bus.Ovf;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL op_timeout: no done within %0d cycles", lat);
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic sub,
                          input logic cin);
    logic [W-1:0] s, es;
    logic co, ov, eco, eov;
    int lat;
    model(x, y, sub, cin, es, eco, eov);
    run_op(x, y, sub, cin, s, co, ov, lat);
    tests++;
    if (s !== es || co !== eco || ov !== eov) begin
      fails++;
      $display("FAIL %s: x=%h y=%h sub=%0d cin=%0d got Sum=%h Cout=%0d Ovf=%0d expected Sum=%h Cout=%0d Ovf=%0d",
               name, x, y, sub, cin, s, co, ov, es, eco, eov);
    end
    tests++;
    if (lat !== NIB + 1) begin
      fails++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, NIB + 1);
    end
    $display("[TB] %s x=%h y=%h sub=%0d cin=%0d -> Sum=%h Cout=%0d Ovf=%0d lat=%0d",
             name, x, y, sub, cin, s, co, ov, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0;
    bus.X = '0; bus.Y = '0; bus.Sub = 1'b0; bus.Cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Sum !== '0 ||
        bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: busy=%0d done=%0d Sum=%h Cout=%0d Ovf=%0d expected all zero",
               bus.busy, bus.done, bus.Sum, bus.Cout, bus.Ovf);
    end
    @(posedge clk); #1; rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    logic [W-1:0] tx [4] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005};
    logic [W-1:0] ty [4] = '{16'h0001, 16'h0001, 16'h1111, 16'h0007};
    logic         tsb[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic         tci[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] es [4] = '{16'h0000, 16'h8000, 16'h2346, 16'hFFFE};
    logic         eco[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic         eov[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op(tx[i], ty[i], tsb[i], tci[i], s, co, ov, lat);
      tests++;
      if (s !== es[i] || co !== eco[i] || ov !== eov[i] || lat !== 5) begin
        fails++;
        $display("FAIL directed_%0d: got Sum=%h Cout=%0d Ovf=%0d lat=%0d expected Sum=%h Cout=%0d Ovf=%0d lat=5",
                 i, s, co, ov, lat, es[i], eco[i], eov[i]);
      end
      $display("[TB] directed_%0d Sum=%h Cout=%0d Ovf=%0d lat=%0d", i, s, co, ov, lat);
      // done must be one cycle only and result must hold in IDLE
      @(negedge clk);
      tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Sum !== es[i]) begin
        fails++;
        $display("FAIL directed_hold_%0d: done=%0d busy=%0d Sum=%h expected done=0 busy=0 Sum=%h",
                 i, bus.done, bus.busy, bus.Sum, es[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom); y = W'($urandom);
      if (i % 6 == 0) x = {1'b0, {(W-1){1'b1}}};
      if (i % 6 == 1) y = x;
      check_op("random", x, y, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] x, y, es, s_at_done;
    logic eco, eov;
    int pulses;
    x = W'($urandom); y = W'($urandom);
    model(x, y, 1'b0, 1'b1, es, eco, eov);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.X = x; bus.Y = y; bus.Sub = 1'b0; bus.Cin = 1'b1;
    pulses = 0; s_at_done = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      bus.start = (c == 2 || c == 5);  // c==2 hits RUN, c==5 hits DONE
      bus.X = W'($urandom); bus.Y = W'($urandom); bus.Sub = 1'($urandom);
      @(negedge clk);
      if (bus.done) begin pulses++; s_at_done = bus.Sum; end
    end
    tests++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL ignore_start_pulses: got %0d expected 1", pulses);
    end
    tests++;
    if (s_at_done !== es || bus.Sum !== es || bus.Cout !== eco || bus.Ovf !== eov) begin
      fails++;
      $display("FAIL ignore_start_result: got Sum=%h/%h Cout=%0d Ovf=%0d expected Sum=%h Cout=%0d Ovf=%0d",
               s_at_done, bus.Sum, bus.Cout, bus.Ovf, es, eco, eov);
    end
    $display("[TB] ignore_start pulses=%0d Sum=%h", pulses, s_at_done);
  endtask

  task automatic test_reset_abort();
    int pulses;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.X = 16'hFFFF; bus.Y = 16'hFFFF; bus.Sub = 1'b0; bus.Cin = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.Sum !== '0 || bus.Cout !== 1'b0 ||
        bus.Ovf !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: busy=%0d done=%0d Sum=%h Cout=%0d Ovf=%0d expected all zero",
               bus.busy, bus.done, bus.Sum, bus.Cout, bus.Ovf);
    end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL reset_abort_quiet: got %0d active cycles expected 0", pulses);
    end
    $display("[TB] reset_abort checked");
    check_op("after_reset", 16'h0001, 16'h0001, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y, es;
    logic eco, eov, prev;
    int last, pulses, bad_gap, bad_width, bad_sum;
    x = W'($urandom); y = W'($urandom);
    model(x, y, 1'b1, 1'b0, es, eco, eov);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.X = x; bus.Y = y; bus.Sub = 1'b1; bus.Cin = 1'b0;
    last = -1; pulses = 0; bad_gap = 0; bad_width = 0; bad_sum = 0; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (prev) bad_width++;
        if (last >= 0 && c - last != NIB + 2) bad_gap++;
        if (bus.Sum !== es || bus.Cout !== eco || bus.Ovf !== eov) bad_sum++;
        last = c; pulses++;
        $display("[TB] back_to_back done at cycle %0d Sum=%h", c, bus.Sum);
      end
      prev = bus.done;
    end
    @(posedge clk); #1; bus.start = 1'b0;
    tests++;
    if (pulses < 6 || bad_gap != 0 || bad_width != 0) begin
      fails++;
      $display("FAIL back_to_back_timing: pulses=%0d bad_gap=%0d bad_width=%0d expected >=6,0,0",
               pulses, bad_gap, bad_width);
    end
    tests++;
    if (bad_sum != 0) begin
      fails++;
      $display("FAIL back_to_back_result: %0d wrong results expected Sum=%h", bad_sum, es);
    end
    repeat (NIB + 2) @(posedge clk);
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
